// File: rtl/config_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Bus field positions follow {mod_id, tile_id}.
package config_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    ADDR,
    DATA,
    ISSUE,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] MAGIC_DEFAULT     = 16'hC0F1;
  localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

  localparam int TILE_ID_LSB = 0;
  localparam int MOD_ID_LSB  = 16;

endpackage

// File: rtl/config_loader.sv
// Write side of the tile configuration bus: turns a framed
// (addr, data) word stream into held bus writes, parked when idle.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT,
  parameter logic [15:0] MAGIC       = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_remain;
  logic [7:0]  r_hold;
  logic [31:0] r_addr_hold;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic [15:0] w_magic;
  logic [15:0] w_count;

  assign in_ready = (r_state != ISSUE) && (r_state != DONE);
  assign busy     = (r_state != HDR) && (r_state != ERR);
  assign w_xfer   = in_valid && in_ready;
  assign w_magic  = in_data[MOD_ID_LSB +: 16];
  assign w_count  = in_data[TILE_ID_LSB +: 16];

  assign config_addr = r_bus_addr;
  assign config_data = r_bus_data;
  assign done        = r_done;
  assign error       = r_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HDR;
      r_remain    <= '0;
      r_hold      <= '0;
      r_addr_hold <= '0;
      r_bus_addr  <= IDLE_ADDR;
      r_bus_data  <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        HDR: begin
          if (w_xfer) begin
            if (w_magic != MAGIC) begin
              r_state <= ERR;
              r_error <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_remain <= w_count;
              r_state  <= ADDR;
            end
          end
        end
        ADDR: begin
          if (w_xfer) begin
            r_addr_hold <= in_data;
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_bus_addr <= r_addr_hold;
            r_bus_data <= in_data;
            r_hold     <= HOLD_INIT;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_hold == 8'd0) begin
            r_bus_addr <= IDLE_ADDR;
            r_bus_data <= '0;
            r_remain   <= r_remain - 16'd1;
            if (r_remain == 16'd1) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ADDR;
            end
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        DONE: r_state <= HDR;
        // Only reset leaves the error state; all input is swallowed.
        ERR: r_state <= ERR;
        default: r_state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: two instances (hold 1 and 4)
// share one stimulus driver; a bus monitor records observed write windows.
module tb_config_loader;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0;
  logic [31:0] d = '0;
  int          sel = 0;

  logic        v0, v1;
  logic        rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [31:0] addr0, addr1, data0, data1;
  logic        o_rdy, o_busy, o_done, o_err;
  logic [31:0] o_addr, o_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wl_q[$];
  int          done_cnt = 0;
  int          viol = 0;
  logic        in_win = 1'b0;
  logic [31:0] cur_a, cur_d;

  logic [31:0] pa[0:7];
  logic [31:0] pd[0:7];

  always #5 clk = ~clk;

  assign v0 = (sel == 0) && v;
  assign v1 = (sel == 1) && v;
  assign o_rdy  = sel == 1 ? rdy1  : rdy0;
  assign o_busy = sel == 1 ? busy1 : busy0;
  assign o_done = sel == 1 ? done1 : done0;
  assign o_err  = sel == 1 ? err1  : err0;
  assign o_addr = sel == 1 ? addr1 : addr0;
  assign o_data = sel == 1 ? data1 : data0;

  config_loader #(.HOLD_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst_n), .in_data(d), .in_valid(v0),
    .in_ready(rdy0), .config_addr(addr0), .config_data(data0),
    .busy(busy0), .done(done0), .error(err0)
  );

  config_loader #(.HOLD_CYCLES(4)) dut1 (
    .clk(clk), .reset(rst_n), .in_data(d), .in_valid(v1),
    .in_ready(rdy1), .config_addr(addr1), .config_data(data1),
    .busy(busy1), .done(done1), .error(err1)
  );

  // Bus monitor: every maximal run of one non-idle (addr,data) is a window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_addr !== IDLE) begin
        if (!in_win || o_addr !== cur_a || o_data !== cur_d) begin
          wa_q.push_back(o_addr);
          wd_q.push_back(o_data);
          wl_q.push_back(1);
        end else begin
          wl_q[wl_q.size()-1] = wl_q[wl_q.size()-1] + 1;
        end
        if (o_rdy !== 1'b0) viol++;
        in_win = 1'b1;
        cur_a = o_addr;
        cur_d = o_data;
      end else begin
        if (o_data !== 32'd0) viol++;
        in_win = 1'b0;
      end
      if (o_done === 1'b1) done_cnt++;
    end
  end

  task automatic mon_clear();
    wa_q.delete();
    wd_q.delete();
    wl_q.delete();
    done_cnt = 0;
    viol = 0;
    in_win = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    v = 1'b0;
    repeat (gap) @(negedge clk);
    v = 1'b1;
    d = w;
    n = 0;
    while (o_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck %b, want 1", o_rdy);
    end
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic gen_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      pa[i] = $urandom & 32'hFFFF_FFFE;
      pd[i] = $urandom;
    end
  endtask

  task automatic send_frame(input int n, input int gmax);
    send_word({16'hC0F1, 16'(n)}, $urandom_range(0, gmax));
    for (int i = 0; i < n; i++) begin
      send_word(pa[i], $urandom_range(0, gmax));
      send_word(pd[i], $urandom_range(0, gmax));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (o_addr !== IDLE || o_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_bus[%0d]: got %h/%h want %h/0", s, o_addr, o_data, IDLE);
      end
      n_checks++;
      if ({o_done, o_err, o_busy, o_rdy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b want 0001", s, {o_done, o_err, o_busy, o_rdy});
      end
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    sel = 0;
    mon_clear();
    send_word(32'hC0F1_0001, 0);
    send_word(32'h0001_0003, 0);
    send_word(32'h0000_0005, 0);
    n_checks++;
    if (o_addr !== 32'h0001_0003 || o_data !== 32'd5 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: got %h/%h rdy %b want 00010003/5 rdy 0", o_addr, o_data, o_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (o_addr !== IDLE || o_data !== 32'd0 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got %h/%h done %b want idle/0 done 1", o_addr, o_data, o_done);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_rdy !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got done %b rdy %b busy %b want 0 1 0", o_done, o_rdy, o_busy);
    end
    n_checks++;
    if (wa_q.size() != 1 || wl_q.size() != 1 || wl_q[0] != 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL single_window: got %0d windows done %0d want 1 window len 1, done 1", wa_q.size(), done_cnt);
    end
  endtask

  task automatic test_multi(input int s, input int n, input int gmax, input string nm);
    int hold;
    hold = (s == 1) ? 4 : 1;
    sel = s;
    mon_clear();
    gen_pairs(n);
    send_frame(n, gmax);
    repeat (hold + 3) @(negedge clk);
    n_checks++;
    if (wa_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d windows want %0d", nm, wa_q.size(), n);
    end
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      n_checks++;
      if (wa_q[i] !== pa[i] || wd_q[i] !== pd[i] || wl_q[i] != hold) begin
        n_fail++;
        $display("FAIL %s_pair%0d: got %h/%h x%0d want %h/%h x%0d", nm, i, wa_q[i], wd_q[i], wl_q[i], pa[i], pd[i], hold);
      end
    end
    n_checks++;
    if (done_cnt != 1 || viol != 0) begin
      n_fail++;
      $display("FAIL %s_done: got done %0d viol %0d want 1 and 0", nm, done_cnt, viol);
    end
  endtask

  task automatic test_bad_header();
    sel = 0;
    mon_clear();
    send_word(32'hBEEF_0002, 0);
    for (int i = 0; i < 4; i++) send_word($urandom & 32'hFFFF_FFFE, $urandom_range(0, 2));
    n_checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_hdr_flags: got err %b busy %b rdy %b want 1 0 1", o_err, o_busy, o_rdy);
    end
    n_checks++;
    if (wa_q.size() != 0 || done_cnt != 0 || viol != 0) begin
      n_fail++;
      $display("FAIL bad_hdr_bus: got %0d windows done %0d want 0 0", wa_q.size(), done_cnt);
    end
    send_word(32'hC0F1_0001, 0);
    send_word(32'h0002_0002, 0);
    send_word(32'h0000_0009, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wa_q.size() != 0 || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_hdr_sticky: got %0d windows err %b want 0 1", wa_q.size(), o_err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_hdr_clear: got err %b want 0", o_err);
    end
  endtask

  task automatic test_zero_count();
    sel = 1;
    mon_clear();
    send_word(32'hC0F1_0000, 0);
    n_checks++;
    if (o_done !== 1'b1 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done %b rdy %b want 1 0", o_done, o_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_rdy !== 1'b1 || wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_after: got done %b rdy %b win %0d want 0 1 0", o_done, o_rdy, wa_q.size());
    end
  endtask

  task automatic test_reset_mid();
    sel = 1;
    mon_clear();
    gen_pairs(3);
    send_word(32'hC0F1_0003, 0);
    send_word(pa[0], 0);
    send_word(pd[0], 0);
    send_word(pa[1], 0);
    send_word(pd[1], 0);
    n_checks++;
    if (o_addr !== pa[1]) begin
      n_fail++;
      $display("FAIL mid_issue: got %h want %h", o_addr, pa[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_addr !== IDLE || o_data !== 32'd0 || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_async: got %h/%h busy %b rdy %b want idle/0 0 1", o_addr, o_data, o_busy, o_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_multi(1, 2, 1, "mid_fresh");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi(1, 3, 0, "multi");
    test_bad_header();
    test_zero_count();
    test_multi(1, 5, 3, "gaps_h4");
    test_multi(0, 5, 3, "gaps_h1");
    test_reset_mid();
    for (int k = 0; k < 4; k++) test_multi(k % 2, $urandom_range(1, 8), 2, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Fabric configuration transmitter: accepts a framed word stream of (address, data) pairs from the host/boot interface and drives the shared `config_addr`/`config_data` bus that every tile's address matchers decode. It is the write side of the tile configuration bus. When no write is in progress it parks the bus on an address no tile matches. It sits at the array edge, one instance per fabric.

## Interface
Parameters:
- `HOLD_CYCLES`, 1, cycles each (addr, data) pair is held on the bus; legal range 1–255.
- `IDLE_ADDR`, 32'hFFFF_FFFF, bus address driven when idle; tile_id field 16'hFFFF is reserved and never assigned to a tile.
- `MAGIC`, 16'hC0F1, required value of header bits [31:16].

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  32  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `config_addr`  out  32  {mod_id[31:16], tile_id[15:0]}, registered.
- `config_data`  out  32  configuration payload, registered.
- `busy`  out  1  frame in progress (states other than HDR and ERR).
- `done`  out  1  one-cycle pulse when a frame finishes.
- `error`  out  1  sticky bad-header flag.

## Operation
- Frame format: header word {MAGIC[31:16], count[15:0]}, followed by `count` pairs, each sent as an address word and then a data word.
- A word transfers on a cycle where `in_valid && in_ready`.
- `in_ready` is 1 in HDR, ADDR, DATA and ERR. It is 0 in ISSUE and DONE.
- States:
  - HDR: wait for the header.
    - Bad magic → ERR, set `error`.
    - count==0 → DONE.
    - Otherwise load the 16-bit remaining counter with count → ADDR.
  - ADDR: capture the address word into a holding register → DATA.
  - DATA: capture the data word. Next cycle `config_addr`/`config_data` show the pair. Load the hold counter with HOLD_CYCLES-1 → ISSUE.
  - ISSUE: hold the bus values. When the hold counter reaches 0:
    - Bus returns to `IDLE_ADDR` with `config_data`=0.
    - Decrement the remaining counter.
    - Remaining reaches 0 → DONE, else → ADDR.
  - DONE: pulse `done` for one cycle → HDR.
  - ERR: accept and discard all words. Leave only via reset. Bus held idle.
- The bus carries a real address only while in ISSUE. In every other state it carries IDLE_ADDR/0.
- Remaining counter is unsigned 16 bits. count 65535 is legal.
- No back-to-back issue: between pairs at least one idle-bus cycle is guaranteed by the ADDR→DATA transfers.

## Timing
- Reset values: `config_addr`=IDLE_ADDR, `config_data`=0, `done`=0, `error`=0, `busy`=0, state HDR, `in_ready`=1 (combinational from state).
- Data word accepted at cycle t → bus valid cycles t+1 … t+HOLD_CYCLES → IDLE_ADDR at t+HOLD_CYCLES+1.
- Last pair: `done` is high on cycle t+HOLD_CYCLES+1. `in_ready` returns to 1 at t+HOLD_CYCLES+2.
- Stalls: `in_valid` low in HDR/ADDR/DATA holds the state. The bus stays idle.
- `in_valid` high during ISSUE/DONE is ignored, because `in_ready`=0. The source must hold the word.
- Reset asserted mid-frame: all outputs take reset values immediately (asynchronously). A partially loaded frame is lost. The next word after release is treated as a header.

## Structure
- Package `config_loader_pkg`:
  - state enum {HDR, ADDR, DATA, ISSUE, DONE, ERR};
  - default constants MAGIC_DEFAULT and IDLE_ADDR_DEFAULT;
  - field-position constants TILE_ID_LSB=0, MOD_ID_LSB=16.
- Single module, no sub-modules. The hold counter and remaining counter are inline.

## Test plan
- Header 32'hC0F1_0001, addr 32'h0001_0003, data 32'h0000_0005, HOLD_CYCLES=1 → `config_addr`=32'h0001_0003 and `config_data`=5 for exactly 1 cycle, then IDLE_ADDR; `done` pulses on the next cycle.
- count=3 with HOLD_CYCLES=4 → three 4-cycle bus windows in stream order; `in_ready`=0 throughout each window; single `done` pulse after the third.
- Header 32'hBEEF_0002 → `error`=1, `busy`=0, bus never leaves IDLE_ADDR; further words are accepted and dropped until `reset` goes low.
- Header count=0 → `done` pulses the cycle after the header; bus stays idle.
- Random `in_valid` gaps within a 5-pair frame → same bus sequence as the gap-free run, shifted in time; no duplicated or dropped pair.
- `reset` pulled low during ISSUE of pair 2 → `config_addr` goes to IDLE_ADDR in the same cycle; after release a fresh valid frame loads correctly.
